serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b - bin, one bit per clock, LSB first.
- Uses a single borrow flip-flop: the complementary-direction companion to the team's full-adder/ripple-carry arithmetic blocks.
- Intended as a low-area subtract/compare engine for the same datapath.
- Operands load on a start pulse; result, borrow-out and signed overflow are registered and announced with a one-cycle done pulse.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk    input   1      rising-edge clock
rst    input   1      asynchronous reset, active-high
start  input   1      request: sample a, b, bin when idle
a      input   WIDTH  minuend
b      input   WIDTH  subtrahend
bin    input   1      borrow-in
busy   output  1      high while an operation is in progress
done   output  1      one-cycle pulse: result outputs just updated
diff   output  WIDTH  difference a - b - bin (mod 2^WIDTH)
bout   output  1      borrow-out (1 when a < b + bin, unsigned)
ovf    output  1      signed two's-complement overflow

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, internal shift regs, bit counter and borrow flop cleared. Takes effect immediately, including mid-operation; the in-flight operation is abandoned and no done is produced.
- States: IDLE, SHIFT.
- IDLE:
  - start=1 at a rising edge: latch a, b, bin into internal shift regs/borrow flop, clear bit counter, go to SHIFT, busy=1.
  - start=0: remain, busy=0.
- SHIFT, per edge:
  - Take a0, b0 (current LSBs), br (borrow flop).
  - Compute d = a0^b0^br and br' = (~a0 & b0) | (~(a0^b0) & br).
  - Shift d into result reg from MSB side; shift a, b regs right; br <= br'; counter++.
- On the edge processing bit WIDTH-1:
  - diff <= completed result; bout <= br'.
  - ovf <= (borrow into MSB) ^ br', equivalently (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]).
  - done <= 1, busy <= 0, state -> IDLE.
- Latency: start sampled at edge t0 -> done=1 and new results visible after edge t0+WIDTH; busy high after edges t0..t0+WIDTH-1.
- done is high exactly one cycle; cleared on the next edge unless another operation completes there (impossible for WIDTH >= 2).
- diff/bout/ovf hold their last values until the next completion; they do not change during SHIFT.
- start while busy (SHIFT): ignored; latched operands are unaffected.
- start in the same cycle done is high: accepted (state is IDLE); back-to-back throughput is one result per WIDTH cycles.
- a, b, bin are only sampled on the accepting edge; later changes have no effect on the operation.
- Arithmetic is modulo 2^WIDTH; borrow chain is identical to ripple subtraction built from full adders with inverted b and carry-in = ~bin.

Test Plan:
- WIDTH=8, a=100, b=37, bin=0, start at t0 -> done only in cycle after t0+8; diff=63, bout=0, ovf=0; busy high exactly 8 cycles.
- a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1, ovf=0. Then a=8'h80, b=8'h01 -> diff=8'h7F, bout=0, ovf=1.
- a=8'h05, b=8'h05, bin=1 -> diff=8'hFF, bout=1, ovf=0; repeat with bin=0 -> diff=8'h00, bout=0.
- start pulsed at t0+3 with different operands during busy -> ignored; first result unchanged; second start asserted in the done cycle -> accepted, its done arrives 8 cycles later with the correct result.
- rst asserted asynchronously at t0+3 mid-operation -> busy, done, diff, bout, ovf = 0 immediately; no done pulse after release; new start after release completes correctly.
- Randomized 1000 operations, all three inputs random -> diff/bout/ovf match reference {bout,diff} = {1'b0,a} - b - bin and signed-overflow rule.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives the request and operands; the slave returns status and results.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single borrow flop ripples through WIDTH cycles. Results, borrow-out and
// signed overflow are registered and announced with a one-cycle done pulse.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             d_bit;
  logic             br_next;
  logic             last_bit;

  // One full-subtractor slice on the current LSBs and the borrow flop.
  always_comb begin
    d_bit    = a_q[0] ^ b_q[0] ^ br_q;
    br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Next-state and datapath control for the IDLE/SHIFT sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d = {d_bit, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        cnt_d = cnt_q + 1'b1;
        if (last_bit) begin
          diff_d  = {d_bit, res_q[WIDTH-1:1]};
          bout_d  = br_next;
          // Borrow into the MSB differs from borrow out of it only on overflow.
          ovf_d   = br_q ^ br_next;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases with literal
// expectations plus randomized operations against an arithmetic reference.
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  bit   cmp_en   = 1'b0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a result becomes visible WIDTH edges after acceptance,
  // computed with plain integer arithmetic.
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  int         m_left = 0;
  logic [W-1:0] m_diff = '0;
  bit         m_bout = 1'b0;
  bit         m_ovf  = 1'b0;
  logic [W-1:0] p_diff;
  bit         p_bout, p_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_left = 0;
      m_diff = '0;   m_bout = 1'b0; m_ovf  = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_diff = p_diff;
          m_bout = p_bout;
          m_ovf  = p_ovf;
        end
      end else if (bus.start) begin
        int u, s;
        u = int'(bus.a) - int'(bus.b) - int'(bus.bin);
        s = int'($signed(bus.a)) - int'($signed(bus.b)) - int'(bus.bin);
        p_diff = u[W-1:0];
        p_bout = (u < 0);
        p_ovf  = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
        m_busy = 1'b1;
        m_left = W;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("busy", bus.busy, m_busy);
      check("done", bus.done, m_done);
      check("diff", bus.diff, m_diff);
      check("bout", bus.bout, m_bout);
      check("ovf",  bus.ovf,  m_ovf);
    end
  end

  // Waits (at negedges) for done; returns the number of negedges waited.
  // Optionally scribbles random inputs while busy to show they are ignored.
  task automatic wait_done(input bit scribble, output int cyc, output int busy_n);
    cyc = 0;
    busy_n = 0;
    while (!bus.done && cyc < 3 * W) begin
      if (bus.busy) busy_n++;
      if (scribble) begin
        bus.start = ($urandom_range(0, 3) == 0);
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.bin   = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    if (!bus.done) check("done_timeout", bus.done, 1);
  endtask

  task automatic launch(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
    bus.a = ia; bus.b = ib; bus.bin = ibin; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ibin, input logic [W-1:0] ed, input logic eb, input logic eo);
    int cyc, busy_n;
    launch(ia, ib, ibin);
    wait_done(1'b0, cyc, busy_n);
    check({nm, "_latency"}, cyc + 1, W + 1);
    check({nm, "_busycyc"}, busy_n, W);
    check({nm, "_diff"}, bus.diff, ed);
    check({nm, "_bout"}, bus.bout, eb);
    check({nm, "_ovf"},  bus.ovf,  eo);
    check({nm, "_model"}, {m_ovf, m_bout, m_diff}, {eo, eb, ed});
  endtask

  initial begin
    int cyc, busy_n;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;

    #3 rst = 1'b1;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_diff", bus.diff, 0);
    check("rst_bout", bus.bout, 0);
    check("rst_ovf",  bus.ovf,  0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    run_op("basic",   8'd100, 8'd37, 1'b0, 8'd63,  1'b0, 1'b0);
    run_op("under",   8'h00,  8'h01, 1'b0, 8'hFF,  1'b1, 1'b0);
    run_op("sovf",    8'h80,  8'h01, 1'b0, 8'h7F,  1'b0, 1'b1);
    run_op("eq_bin1", 8'h05,  8'h05, 1'b1, 8'hFF,  1'b1, 1'b0);
    run_op("eq_bin0", 8'h05,  8'h05, 1'b0, 8'h00,  1'b0, 1'b0);

    // Start pulsed during busy must be ignored.
    launch(8'd100, 8'd37, 1'b0);
    @(negedge clk); @(negedge clk);
    bus.a = 8'd1; bus.b = 8'd2; bus.bin = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(1'b0, cyc, busy_n);
    check("ignored_diff", bus.diff, 8'd63);
    check("ignored_bout", bus.bout, 0);
    // Start in the done cycle is accepted: 127 - (-1) overflows.
    run_op("b2b", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

    // Asynchronous reset mid-operation.
    launch(8'd100, 8'd37, 1'b0);
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_diff", bus.diff, 0);
    check("arst_bout", bus.bout, 0);
    check("arst_ovf",  bus.ovf,  0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      check("arst_no_done", bus.done, 0);
    end
    run_op("post_rst", 8'd200, 8'd50, 1'b1, 8'd149, 1'b0, 1'b0);

    // Randomized operations, with random gaps and scribbled inputs while busy.
    for (int n = 0; n < 1000; n++) begin
      launch(W'($urandom), W'($urandom), 1'($urandom));
      wait_done(1'b1, cyc, busy_n);
      if ($urandom_range(0, 3) == 0) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) @(negedge clk);
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
